// File: rtl/window_memory_array.sv
// window_memory_array: DIM_Y x DIM_X word memory with K-word wrapped write bursts,
// KxK wrapped window reads (one-cycle latency) and a row-per-cycle clear sweep.
// Optional feature: define WINDOW_MEM_WR_BYPASS_EN to forward same-cycle write data to a read.
module window_memory_array #(
    parameter int unsigned MEM_WIDTH = 16,
    parameter int unsigned DIM_Y     = 128,
    parameter int unsigned DIM_X     = 66,
    parameter int unsigned K         = 3
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          write_en,
    input  logic [K*MEM_WIDTH-1:0]        din,
    input  logic [7:0]                    x_write,
    input  logic [7:0]                    y_write,
    input  logic                          rd_req,
    input  logic [7:0]                    x_read,
    input  logic [7:0]                    y_read,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic                          rd_valid,
    output logic signed [K*MEM_WIDTH-1:0] output_grid [K]
);

    localparam int unsigned XW = $clog2(DIM_X);
    localparam int unsigned YW = $clog2(DIM_Y);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                        state_q;
    logic [YW-1:0]                 row_q;
    logic                          clear_busy_q;
    logic                          rd_valid_q;
    logic signed [K*MEM_WIDTH-1:0] grid_q [K];

    logic [MEM_WIDTH-1:0]          mem [DIM_Y][DIM_X];

    logic                          wr_commit;
    logic                          rd_accept;
    logic [YW-1:0]                 wr_row;
    logic [XW-1:0]                 wr_col [K];
    logic [YW-1:0]                 rd_row [K];
    logic [XW-1:0]                 rd_col [K];
    logic signed [K*MEM_WIDTH-1:0] rd_grid [K];

    function automatic logic [XW-1:0] wrap_x(input int unsigned v);
        int unsigned m;
        m = v % DIM_X;
        return m[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] wrap_y(input int unsigned v);
        int unsigned m;
        m = v % DIM_Y;
        return m[YW-1:0];
    endfunction

    // A clear request in the same cycle wins over a write; reads are still served.
    assign wr_commit = (state_q == StIdle) && write_en && !clear_req;
    assign rd_accept = (state_q == StIdle) && rd_req;

    // Wrapped row/column addresses for the write burst and the read window.
    always_comb begin
        wr_row = wrap_y({24'd0, y_write});
        for (int unsigned i = 0; i < K; i++) begin
            wr_col[i] = wrap_x({24'd0, x_write} + i);
            rd_row[i] = wrap_y({24'd0, y_read} + i);
            rd_col[i] = wrap_x({24'd0, x_read} + i);
        end
    end

    // Gather the KxK window; optionally overlay the burst being written this cycle.
    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            rd_grid[r] = '0;
            for (int unsigned c = 0; c < K; c++) begin
                rd_grid[r][c*MEM_WIDTH +: MEM_WIDTH] = mem[rd_row[r]][rd_col[c]];
`ifdef WINDOW_MEM_WR_BYPASS_EN
                for (int unsigned i = 0; i < K; i++) begin
                    if (wr_commit && (rd_row[r] == wr_row) && (rd_col[c] == wr_col[i])) begin
                        rd_grid[r][c*MEM_WIDTH +: MEM_WIDTH] = din[i*MEM_WIDTH +: MEM_WIDTH];
                    end
                end
`endif
            end
        end
    end

    // Storage array: no reset, the post-reset sweep zeroes it one row per cycle.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            for (int unsigned x = 0; x < DIM_X; x++) begin
                mem[row_q][XW'(x)] <= '0;
            end
        end else if (wr_commit) begin
            for (int unsigned i = 0; i < K; i++) begin
                mem[wr_row][wr_col[i]] <= din[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    // Control FSM with registered busy/valid flags and the registered read window.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q      <= StClear;
            row_q        <= '0;
            clear_busy_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            for (int unsigned r = 0; r < K; r++) begin
                grid_q[r] <= '0;
            end
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rd_accept) begin
                        rd_valid_q <= 1'b1;
                        for (int unsigned r = 0; r < K; r++) begin
                            grid_q[r] <= rd_grid[r];
                        end
                    end
                    if (clear_req) begin
                        state_q      <= StClear;
                        row_q        <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    if (row_q == YW'(DIM_Y - 1)) begin
                        state_q      <= StIdle;
                        row_q        <= '0;
                        clear_busy_q <= 1'b0;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= StClear;
                    row_q        <= '0;
                    clear_busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign clear_busy  = clear_busy_q;
    assign rd_valid    = rd_valid_q;
    assign output_grid = grid_q;

endmodule

// File: doc/window_memory_array.md
WINDOW_MEMORY_ARRAY -- requirements
Module: window_memory_array

Interface
REQ-001 Parameter MEM_WIDTH, default 16, bits per memory location.
REQ-002 Parameter DIM_Y, default 128, rows; legal range 2..256.
REQ-003 Parameter DIM_X, default 66, columns; legal range 2..256.
REQ-004 Parameter K, default 3, read-window edge and write-burst length; legal range 1..min(DIM_X,DIM_Y).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 arst_n_in  input  1  reset, asynchronous, active-low.
REQ-007 write_en  input  1  write K adjacent locations this cycle.
REQ-008 din  input  K*MEM_WIDTH  write data; slice i (bits i*MEM_WIDTH upward) goes to column x_write+i.
REQ-009 x_write, y_write  input  8 each  write start column and row.
REQ-010 rd_req  input  1  request a KxK window read.
REQ-011 x_read, y_read  input  8 each  top-left corner of the read window.
REQ-012 clear_req  input  1  one-cycle pulse that starts a full-array clear.
REQ-013 clear_busy  output  1  high while a clear sweep is in progress.
REQ-014 rd_valid  output  1  output_grid holds the window for the rd_req of the previous cycle.
REQ-015 output_grid  output  signed K rows x K*MEM_WIDTH  row r holds (x_read+c, y_read+r) in slice c.

Function
REQ-016 All column indices SHALL be reduced modulo DIM_X and all row indices modulo DIM_Y, on both read and write; windows and bursts wrap.
REQ-017 Writes SHALL commit on the clk edge where write_en=1 and the FSM is IDLE and clear_req=0.
REQ-018 Reads SHALL have 1-cycle latency: rd_req=1 in IDLE at edge N -> output_grid and rd_valid=1 registered at edge N.
REQ-019 With no accepted rd_req, rd_valid SHALL be 0 and output_grid SHALL hold its last value.
REQ-020 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clear_req=1; CLEAR->IDLE after the row counter reaches DIM_Y-1.
REQ-021 In CLEAR, one row (all DIM_X locations) SHALL be zeroed per cycle, rows 0..DIM_Y-1 in order: exactly DIM_Y cycles with clear_busy=1.
REQ-022 In CLEAR, write_en, rd_req and clear_req SHALL be ignored; rd_valid SHALL be 0.
REQ-023 clear_req with write_en in the same IDLE cycle: clear wins, write dropped.
REQ-024 clear_req with rd_req in the same IDLE cycle: read served (pre-clear data, rd_valid=1 next cycle), then CLEAR.
REQ-025 Write bursts with overlapping wrapped columns (K>DIM_X excluded by REQ-004) SHALL not occur; each burst writes K distinct locations.

Reset
REQ-026 On arst_n_in=0: rd_valid=0, output_grid=0, row counter=0, FSM forced to CLEAR, clear_busy=1 asynchronously.
REQ-027 After release, the FSM SHALL complete an initialisation sweep of DIM_Y cycles before entering IDLE; array contents need no async reset.
REQ-028 Reset asserted mid-sweep or mid-read SHALL restart the sweep from row 0 and drop any pending read.

Configuration
REQ-029 Macro WINDOW_MEM_WR_BYPASS_EN defined: a read accepted in the same cycle as a committed write SHALL return the newly written data at every overlapping location.
REQ-030 Macro undefined: such a read SHALL return the data held before that write (read-before-write).

Verification
REQ-031 Reset, release -> clear_busy=1 for exactly 128 cycles (defaults), then 0; read of (0,0) -> all 9 locations 0.
REQ-032 Write din=0x0003_0002_0001 at (10,5); rd_req at (10,5) next cycle -> rd_valid=1 one cycle later, output_grid[0]=0x0003_0002_0001.
REQ-033 Write at (64,127) with DIM_X=66 -> columns 64,65,0 of row 127 written; read at (64,126) -> row 1 holds the three values, wrapped correctly.
REQ-034 Same-cycle write (20,20)=0xAAAA_BBBB_CCCC and read (20,20) -> old data without WINDOW_MEM_WR_BYPASS_EN, new data with it.
REQ-035 clear_req with write_en in IDLE -> write dropped, clear_busy=1 for 128 cycles, rd_req during sweep gives rd_valid=0.
REQ-036 arst_n_in pulsed low at sweep row 60 -> sweep restarts at row 0, clear_busy low only after 128 further cycles.
